// File: rtl/spi_sram_responder_pkg.sv
// Shared types, SPI SRAM opcodes and store byte-enable decoding helpers for the SPI SRAM responder.
package spi_sram_responder_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StData,
        StGap,
        StAck
    } spi_state_t;

    localparam logic [7:0] SpiCmdRead  = 8'h03;
    localparam logic [7:0] SpiCmdWrite = 8'h02;

    // Only contiguous, naturally aligned byte/half/word lane groups can be sent as one burst.
    function automatic logic be_legal(input logic [3:0] be);
        case (be)
            4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] be_low_lane(input logic [3:0] be);
        if (be[0]) return 2'd0;
        else if (be[1]) return 2'd1;
        else if (be[2]) return 2'd2;
        else return 2'd3;
    endfunction

    function automatic logic [2:0] be_count(input logic [3:0] be);
        return {2'b00, be[0]} + {2'b00, be[1]} + {2'b00, be[2]} + {2'b00, be[3]};
    endfunction

endpackage

// File: rtl/spi_sram_responder_shift_engine.sv
// SPI mode 0 bit engine: SCK divider, 8-bit TX/RX shifters, per-bit and per-byte done strobes.
module spi_sram_responder_shift_engine #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       load,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic       sck,
    output logic       mosi,
    output logic       bit_done,
    output logic       byte_done,
    output logic [7:0] rx_byte
);

    localparam int unsigned DivW = $clog2(2 * CLK_DIV);
    localparam logic [DivW-1:0] RiseAt = DivW'(CLK_DIV - 1);
    localparam logic [DivW-1:0] FallAt = DivW'(2 * CLK_DIV - 1);

    logic [DivW-1:0] div_q, div_d;
    logic            sck_q, sck_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      tx_q, tx_d;
    logic [7:0]      rx_q, rx_d;

    assign bit_done  = en & (div_q == FallAt);
    assign byte_done = bit_done & (bit_q == 3'd7);

    always_comb begin
        div_d = div_q;
        sck_d = sck_q;
        bit_d = bit_q;
        tx_d  = tx_q;
        rx_d  = rx_q;
        if (load) begin
            div_d = '0;
            sck_d = 1'b0;
            bit_d = 3'd0;
            tx_d  = tx_byte;
        end else if (!en) begin
            div_d = '0;
            sck_d = 1'b0;
            bit_d = 3'd0;
        end else if (div_q == RiseAt) begin
            sck_d = 1'b1;
            rx_d  = {rx_q[6:0], miso};
            div_d = div_q + 1'b1;
        end else if (bit_done) begin
            // Falling edge: advance MOSI, or pull in the next byte after bit 0.
            sck_d = 1'b0;
            div_d = '0;
            bit_d = bit_q + 3'd1;
            tx_d  = (bit_q == 3'd7) ? tx_byte : {tx_q[6:0], 1'b0};
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            sck_q <= 1'b0;
            bit_q <= 3'd0;
            tx_q  <= 8'h00;
            rx_q  <= 8'h00;
        end else begin
            div_q <= div_d;
            sck_q <= sck_d;
            bit_q <= bit_d;
            tx_q  <= tx_d;
            rx_q  <= rx_d;
        end
    end

    assign sck     = sck_q;
    assign mosi    = en & tx_q[7];
    assign rx_byte = rx_q;

endmodule

// File: rtl/spi_sram_responder.sv
// RAM request responder that serves each load/store as one 23LC-style serial SRAM transaction.
module spi_sram_responder
    import spi_sram_responder_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned ADDR_W  = 24,
    parameter int unsigned CS_IDLE = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_ren,
    input  logic        ram_wen,
    input  logic [31:0] ram_addr,
    input  logic [31:0] ram_store,
    input  logic [3:0]  ram_byte_en,
    output logic [31:0] ram_load,
    output logic        ram_busy,
    output logic        ram_err,
    output logic        spi_sck,
    output logic        spi_cs_n,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    spi_state_t        state_q, state_d;
    logic [5:0]        bit_cnt_q, bit_cnt_d;
    logic              rd_q, rd_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [2:0]        nbytes_q, nbytes_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       load_q, load_d;

    logic       req, legal, shifting, eng_load, bit_done, byte_done, phase_end, tx_from_addr, ack;
    logic [1:0] low_lane;
    logic [5:0] phase_len;
    logic [7:0] tx_byte, rx_byte;
    logic [31:0] rx_word;
    logic       unused_addr;

    assign unused_addr = ^{ram_addr[31:ADDR_W], ram_addr[1:0]};

    assign req      = ram_ren | ram_wen;
    assign legal    = be_legal(ram_byte_en);
    assign low_lane = be_low_lane(ram_byte_en);
    assign shifting = (state_q == StCmd) | (state_q == StAddr) | (state_q == StData);
    assign eng_load = (state_q == StIdle) & req & (ram_ren | legal);
    assign rx_word  = {rx_byte, rdata_q[31:8]};

    always_comb begin
        case (state_q)
            StCmd:   phase_len = 6'd8;
            StAddr:  phase_len = 6'(ADDR_W);
            StData:  phase_len = rd_q ? 6'd32 : {nbytes_q, 3'b000};
            default: phase_len = 6'd0;
        endcase
    end

    assign phase_end    = bit_done & (bit_cnt_q == phase_len - 6'd1);
    assign tx_from_addr = (state_q == StCmd) | ((state_q == StAddr) & ~phase_end);

    // Byte the engine loads next: opcode at start, then address bytes, then store data bytes.
    always_comb begin
        if (state_q == StIdle) tx_byte = ram_ren ? SpiCmdRead : SpiCmdWrite;
        else if (tx_from_addr) tx_byte = addr_q[ADDR_W-1 -: 8];
        else                   tx_byte = data_q[7:0];
    end

    spi_sram_responder_shift_engine #(
        .CLK_DIV (CLK_DIV)
    ) u_engine (
        .clk       (clk),
        .rst       (rst),
        .en        (shifting),
        .load      (eng_load),
        .tx_byte   (tx_byte),
        .miso      (spi_miso),
        .sck       (spi_sck),
        .mosi      (spi_mosi),
        .bit_done  (bit_done),
        .byte_done (byte_done),
        .rx_byte   (rx_byte)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (req) state_d = (ram_ren | legal) ? StCmd : StAck;
            StCmd:   if (phase_end) state_d = StAddr;
            StAddr:  if (phase_end) state_d = StData;
            StData:  if (phase_end) state_d = StGap;
            StGap:   if (bit_cnt_q == 6'(CS_IDLE - 1)) state_d = StAck;
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        rd_d      = rd_q;
        err_d     = err_q;
        addr_d    = addr_q;
        data_d    = data_q;
        nbytes_d  = nbytes_q;
        rdata_d   = rdata_q;
        load_d    = load_q;
        case (state_q)
            StIdle: begin
                bit_cnt_d = 6'd0;
                if (req) begin
                    rd_d  = ram_ren;
                    err_d = ~ram_ren & ~legal;
                    if (ram_ren) begin
                        addr_d   = {ram_addr[ADDR_W-1:2], 2'b00};
                        data_d   = 32'h0;
                        nbytes_d = 3'd4;
                    end else begin
                        addr_d   = {ram_addr[ADDR_W-1:2], low_lane};
                        data_d   = ram_store >> {low_lane, 3'b000};
                        nbytes_d = be_count(ram_byte_en);
                    end
                end
            end
            StCmd, StAddr, StData: begin
                if (phase_end) bit_cnt_d = 6'd0;
                else if (bit_done && bit_cnt_q != phase_len) bit_cnt_d = bit_cnt_q + 6'd1;
                if (byte_done) begin
                    if (tx_from_addr) addr_d = addr_q << 8;
                    else              data_d = data_q >> 8;
                end
                if (state_q == StData && rd_q && byte_done) begin
                    rdata_d = rx_word;
                    if (phase_end) load_d = rx_word;
                end
            end
            StGap:   bit_cnt_d = bit_cnt_q + 6'd1;
            default: bit_cnt_d = 6'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_q <= 6'd0;
            rd_q      <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            data_q    <= 32'h0;
            nbytes_q  <= 3'd0;
            rdata_q   <= 32'h0;
            load_q    <= 32'h0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            rd_q      <= rd_d;
            err_q     <= err_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            nbytes_q  <= nbytes_d;
            rdata_q   <= rdata_d;
            load_q    <= load_d;
        end
    end

    always_comb begin
        ack      = (state_q == StAck);
        ram_busy = req & ~ack;
        ram_err  = ack & err_q;
        spi_cs_n = ~shifting;
        ram_load = load_q;
    end

endmodule

// File: tb/tb_spi_sram_responder.sv
// Directed bench with a behavioural 23LC-style SPI SRAM on the pins and queue-based scoreboarding.
module tb_spi_sram_responder;

    localparam int unsigned CLK_DIV = 2;
    localparam int unsigned ADDR_W  = 24;
    localparam int unsigned CS_IDLE = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        ram_ren, ram_wen;
    logic [31:0] ram_addr, ram_store;
    logic [3:0]  ram_byte_en;
    logic [31:0] ram_load;
    logic        ram_busy, ram_err;
    logic        spi_sck, spi_cs_n, spi_mosi, spi_miso;

    always #5 clk = ~clk;

    spi_sram_responder #(
        .CLK_DIV (CLK_DIV),
        .ADDR_W  (ADDR_W),
        .CS_IDLE (CS_IDLE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ram_ren     (ram_ren),
        .ram_wen     (ram_wen),
        .ram_addr    (ram_addr),
        .ram_store   (ram_store),
        .ram_byte_en (ram_byte_en),
        .ram_load    (ram_load),
        .ram_busy    (ram_busy),
        .ram_err     (ram_err),
        .spi_sck     (spi_sck),
        .spi_cs_n    (spi_cs_n),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [7:0]  mem [0:1023];
    logic [7:0]  cap_q[$];
    logic [7:0]  exp_bytes[$];
    logic [31:0] exp_load[$];

    int          m_bits = 0;
    logic [7:0]  m_sh   = 8'h00;
    logic [7:0]  m_cmd  = 8'h00;
    logic [23:0] m_addr = 24'h0;
    int          cs_falls = 0;
    int          cs_run   = 0;
    int          min_high = 100000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // SRAM model: new frame on CS fall, capture MOSI on SCK rise.
    initial forever begin
        @(negedge spi_cs_n);
        m_bits = 0;
        m_cmd  = 8'h00;
        cs_falls++;
    end

    initial forever begin
        @(posedge spi_sck);
        if (!spi_cs_n) begin
            m_sh = {m_sh[6:0], spi_mosi};
            m_bits++;
            if (m_bits % 8 == 0) begin
                cap_q.push_back(m_sh);
                if (m_bits == 8) m_cmd = m_sh;
                else if (m_bits <= 32) m_addr = {m_addr[15:0], m_sh};
                else if (m_cmd == 8'h02) mem[int'(m_addr[9:0]) + (m_bits - 40) / 8] = m_sh;
            end
        end
    end

    initial begin
        int k;
        int idx;
        logic [7:0] b;
        spi_miso = 1'b0;
        forever begin
            @(negedge spi_sck);
            if (!spi_cs_n && m_cmd == 8'h03 && m_bits >= 32) begin
                k   = m_bits - 32;
                idx = int'(m_addr[9:0]) + k / 8;
                b   = mem[idx];
                spi_miso = b[7 - (k % 8)];
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (spi_cs_n) cs_run++;
        else begin
            if (cs_run > 0 && cs_run < min_high) min_high = cs_run;
            cs_run = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic start_req(input logic ren, input logic wen, input logic [31:0] addr,
                             input logic [31:0] store, input logic [3:0] be);
        @(posedge clk);
        #1;
        ram_ren     = ren;
        ram_wen     = wen;
        ram_addr    = addr;
        ram_store   = store;
        ram_byte_en = be;
    endtask

    task automatic drop_req;
        @(posedge clk);
        #1;
        ram_ren = 1'b0;
        ram_wen = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (!ram_busy) break;
        end
        check("busy_fell", ram_busy, 1'b0);
    endtask

    task automatic expect_bytes(input string tag, input int extra);
        logic [7:0] a;
        logic [7:0] e;
        check({tag, "_count"}, cap_q.size(), exp_bytes.size() + extra);
        while (exp_bytes.size() > 0) begin
            e = exp_bytes.pop_front();
            a = (cap_q.size() > 0) ? cap_q.pop_front() : 8'hxx;
            check(tag, a, e);
        end
        cap_q.delete();
    endtask

    initial begin
        int c;
        int falls;
        logic [3:0] bad_be [2];
        bad_be[0] = 4'b0101;
        bad_be[1] = 4'b0000;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h5A;
        mem[256] = 8'h11; mem[257] = 8'h22; mem[258] = 8'h33; mem[259] = 8'h44;
        mem[260] = 8'h55; mem[261] = 8'h66; mem[262] = 8'h77; mem[263] = 8'h88;
        rst = 1'b1;
        ram_ren = 1'b0; ram_wen = 1'b0; ram_addr = 32'h0; ram_store = 32'h0; ram_byte_en = 4'h0;

        repeat (3) @(negedge clk);
        check("rst_cs_n", spi_cs_n, 1'b1);
        check("rst_sck", spi_sck, 1'b0);
        check("rst_mosi", spi_mosi, 1'b0);
        check("rst_load", ram_load, 32'h0);
        check("rst_err", ram_err, 1'b0);
        check("rst_busy", ram_busy, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Asynchronous reset in the middle of the address phase of a read.
        start_req(1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
        repeat (60) @(negedge clk);
        check("midaddr_cs_low", spi_cs_n, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("midrst_cs_n", spi_cs_n, 1'b1);
        check("midrst_sck", spi_sck, 1'b0);
        check("midrst_busy", ram_busy, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ram_ren = 1'b0;
        repeat (5) @(negedge clk);
        check("postrst_cs_n", spi_cs_n, 1'b1);
        check("postrst_load", ram_load, 32'h0);
        cap_q.delete();

        // Word read from an unaligned address.
        exp_bytes = '{8'h03, 8'h00, 8'h01, 8'h00};
        exp_load.push_back(32'h4433_2211);
        start_req(1'b1, 1'b0, 32'h0000_0102, 32'h0, 4'h0);
        wait_done(400, c);
        check("rd_latency", c, 260);
        check("rd_load", ram_load, exp_load.pop_front());
        check("rd_err", ram_err, 1'b0);
        expect_bytes("rd_mosi", 4);
        drop_req();

        // Byte store to lane 2.
        exp_bytes = '{8'h02, 8'h00, 8'h02, 8'h02, 8'hBB};
        start_req(1'b0, 1'b1, 32'h200, 32'hAABB_CCDD, 4'b0100);
        wait_done(400, c);
        check("wb_latency", c, 164);
        check("wb_load_kept", ram_load, 32'h4433_2211);
        expect_bytes("wb_mosi", 0);
        drop_req();
        check("wb_mem202", mem[514], 8'hBB);
        check("wb_mem201", mem[513], 8'h5A);
        check("wb_mem203", mem[515], 8'h5A);

        // Upper half store.
        exp_bytes = '{8'h02, 8'h00, 8'h03, 8'h02, 8'h34, 8'h12};
        start_req(1'b0, 1'b1, 32'h300, 32'h1234_5678, 4'b1100);
        wait_done(400, c);
        check("wh_latency", c, 196);
        expect_bytes("wh_mosi", 0);
        drop_req();
        check("wh_mem302", mem[770], 8'h34);
        check("wh_mem303", mem[771], 8'h12);
        check("wh_mem301", mem[769], 8'h5A);

        // Illegal byte enables: no SPI traffic, error pulse with ack.
        for (int i = 0; i < 2; i++) begin
            falls = cs_falls;
            start_req(1'b0, 1'b1, 32'h400, 32'hFFFF_FFFF, bad_be[i]);
            wait_done(10, c);
            check("ill_latency", c, 2);
            check("ill_err", ram_err, 1'b1);
            drop_req();
            @(negedge clk);
            check("ill_err_pulse", ram_err, 1'b0);
            check("ill_no_cs", cs_falls, falls);
        end

        // Back-to-back: request held across ack; second one has ren&wen together.
        exp_bytes = '{8'h03, 8'h00, 8'h01, 8'h00};
        exp_load.push_back(32'h4433_2211);
        start_req(1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
        wait_done(400, c);
        check("bb1_load", ram_load, exp_load.pop_front());
        expect_bytes("bb1_mosi", 4);
        ram_wen     = 1'b1;
        ram_addr    = 32'h104;
        ram_byte_en = 4'b0001;
        ram_store   = 32'hFFFF_FFFF;
        exp_bytes   = '{8'h03, 8'h00, 8'h01, 8'h04};
        exp_load.push_back(32'h8877_6655);
        @(negedge clk);
        check("bb_idle_cs_n", spi_cs_n, 1'b1);
        check("bb_idle_busy", ram_busy, 1'b1);
        @(negedge clk);
        check("bb_cmd_cs_n", spi_cs_n, 1'b0);
        wait_done(400, c);
        check("bb2_latency", c, 258);
        check("bb2_load", ram_load, exp_load.pop_front());
        expect_bytes("bb2_mosi", 4);
        drop_req();
        check("bb2_no_write", mem[260], 8'h55);
        check("cs_idle_min", min_high >= int'(CS_IDLE), 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
